// File: rtl/eth_llc_pkg.sv
// Shared types and header layout constants for the multi-channel LLC decoder.
package eth_llc_pkg;

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_HDR,
        ST_PAY,
        ST_DROP
    } llc_state_e;

    // Byte offsets within the Ethernet header; byte 0 is the DA MSB.
    localparam logic [3:0]  DA_OFF    = 4'd0;
    localparam logic [3:0]  SA_OFF    = 4'd6;
    localparam logic [3:0]  LT_OFF    = 4'd12;
    localparam logic [3:0]  HDR_LEN   = 4'd14;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_stat_cnt.sv
// Saturating statistics counter; a clear wins over a simultaneous increment.
module eth_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clki,
    input  logic             rsti,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clki) begin
        if (rsti || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/eth_llc_decode_mc.sv
// Ethernet header parser: DA/type filter, payload demux to NUM_CH channels, statistics.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RESYNC | discard bytes until the first tlast after reset
// ST_HDR    | capture DA/SA/LT bytes 0..13, decide accept/drop at byte 13
// ST_PAY    | forward payload to the selected channel, 1-cycle latency
// ST_DROP   | discard the rest of a filtered frame
module eth_llc_decode_mc
    import eth_llc_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC     = 48'h7FFF_FFFF_FFFF,
    parameter logic [15:0] PROCT_TYP     = 16'hFF00,
    parameter int          NUM_CH        = 4,
    parameter int          CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter bit          RESYNC_ON_RST = 1'b1,
    parameter int          CNT_W         = 32
) (
    input  logic              clki,
    input  logic              rsti,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [NUM_CH-1:0] m_axis_tvalid,
    output logic [NUM_CH-1:0] m_axis_tlast,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              remote_mac_en_o,
    output logic [47:0]       remote_mac_o,
    output logic [CH_W-1:0]   remote_ch_o,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_accept_o,
    output logic [CNT_W-1:0]  cnt_drop_filt_o,
    output logic [CNT_W-1:0]  cnt_drop_runt_o
);

    llc_state_e        state_q, state_d;
    logic [3:0]        idx_q;
    logic [47:0]       da_q, sa_q;
    logic [7:0]        lt_hi_q;
    logic [15:0]       lt_live;
    logic [CH_W-1:0]   ch_live;
    logic [NUM_CH-1:0] ch_1h;
    logic              hdr_end, da_ok, type_ok, ch_ok;
    logic              inc_acc, inc_filt, inc_runt, pay_beat;

    // The filter decision uses the byte on the bus as LT[7:0], so no extra cycle is spent.
    assign lt_live = {lt_hi_q, s_axis_tdata};
    assign ch_live = lt_live[CH_W-1:0];
    assign ch_1h   = NUM_CH'(1) << remote_ch_o;

    always_ff @(posedge clki) begin
        if (rsti) begin
            state_q <= RESYNC_ON_RST ? ST_RESYNC : ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        inc_acc  = 1'b0;
        inc_filt = 1'b0;
        inc_runt = 1'b0;
        pay_beat = 1'b0;
        hdr_end  = (idx_q == HDR_LEN - 4'd1);
        da_ok    = (da_q == LOCAL_MAC) || (ACCEPT_BCAST && (da_q == BCAST_MAC));
        type_ok  = ({lt_live[15:CH_W], {CH_W{1'b0}}} == PROCT_TYP);
        ch_ok    = (int'(ch_live) < NUM_CH);
        if (s_axis_tvalid) begin
            unique case (state_q)
                ST_RESYNC: if (s_axis_tlast) state_d = ST_HDR;
                ST_HDR: begin
                    if (s_axis_tlast) begin
                        inc_runt = 1'b1;
                    end else if (hdr_end) begin
                        if (da_ok && type_ok && ch_ok) begin
                            state_d = ST_PAY;
                            inc_acc = 1'b1;
                        end else begin
                            state_d  = ST_DROP;
                            inc_filt = 1'b1;
                        end
                    end
                end
                ST_PAY: begin
                    pay_beat = 1'b1;
                    if (s_axis_tlast) state_d = ST_HDR;
                end
                ST_DROP: if (s_axis_tlast) state_d = ST_HDR;
                default: state_d = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clki) begin
        if (rsti) begin
            idx_q           <= DA_OFF;
            da_q            <= '0;
            sa_q            <= '0;
            lt_hi_q         <= '0;
            m_axis_tvalid   <= '0;
            m_axis_tlast    <= '0;
            m_axis_tdata    <= '0;
            m_axis_tuser    <= 1'b0;
            remote_mac_en_o <= 1'b0;
            remote_mac_o    <= '0;
            remote_ch_o     <= '0;
        end else begin
            m_axis_tvalid   <= '0;
            m_axis_tlast    <= '0;
            remote_mac_en_o <= 1'b0;
            if (s_axis_tvalid && (state_q == ST_HDR)) begin
                if (s_axis_tlast || hdr_end) begin
                    idx_q <= DA_OFF;
                end else begin
                    idx_q <= idx_q + 4'd1;
                end
                if (idx_q < SA_OFF) begin
                    da_q <= {da_q[39:0], s_axis_tdata};
                end else if (idx_q < LT_OFF) begin
                    sa_q <= {sa_q[39:0], s_axis_tdata};
                end else if (idx_q == LT_OFF) begin
                    lt_hi_q <= s_axis_tdata;
                end
            end
            if (inc_acc) begin
                remote_mac_en_o <= 1'b1;
                remote_mac_o    <= sa_q;
                remote_ch_o     <= ch_live;
            end
            if (pay_beat) begin
                m_axis_tvalid <= ch_1h;
                m_axis_tlast  <= s_axis_tlast ? ch_1h : '0;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tuser  <= s_axis_tlast & s_axis_tuser;
            end
        end
    end

    eth_stat_cnt #(.CNT_W(CNT_W)) u_cnt_acc (
        .clki (clki),
        .rsti (rsti),
        .clr  (cnt_clr),
        .inc  (inc_acc),
        .cnt  (cnt_accept_o)
    );

    eth_stat_cnt #(.CNT_W(CNT_W)) u_cnt_filt (
        .clki (clki),
        .rsti (rsti),
        .clr  (cnt_clr),
        .inc  (inc_filt),
        .cnt  (cnt_drop_filt_o)
    );

    eth_stat_cnt #(.CNT_W(CNT_W)) u_cnt_runt (
        .clki (clki),
        .rsti (rsti),
        .clr  (cnt_clr),
        .inc  (inc_runt),
        .cnt  (cnt_drop_runt_o)
    );

endmodule

// File: tb/tb_eth_llc_decode_mc.sv
// Bench for eth_llc_decode_mc: three parameterisations share one input stream,
// each checked cycle-by-cycle against a frame-level reference model.
module tb_eth_llc_decode_mc;

    localparam logic [47:0] LOCAL = 48'h7FFF_FFFF_FFFF;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic       clki = 1'b0;
    logic       rsti;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tuser, cnt_clr;

    logic [3:0]  o_tv   [3];
    logic [3:0]  o_tl   [3];
    logic [7:0]  o_td   [3];
    logic        o_tu   [3];
    logic        o_en   [3];
    logic [47:0] o_rmac [3];
    logic [1:0]  o_rch  [3];
    logic [31:0] o_acc  [3];
    logic [31:0] o_filt [3];
    logic [31:0] o_runt [3];
    logic [3:0]  c_acc, c_filt, c_runt;

    assign o_acc[2]  = {28'd0, c_acc};
    assign o_filt[2] = {28'd0, c_filt};
    assign o_runt[2] = {28'd0, c_runt};

    always #5 clki = ~clki;

    eth_llc_decode_mc u_dflt (
        .clki(clki), .rsti(rsti), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tvalid(o_tv[0]),
        .m_axis_tlast(o_tl[0]), .m_axis_tdata(o_td[0]), .m_axis_tuser(o_tu[0]),
        .remote_mac_en_o(o_en[0]), .remote_mac_o(o_rmac[0]), .remote_ch_o(o_rch[0]),
        .cnt_clr(cnt_clr), .cnt_accept_o(o_acc[0]), .cnt_drop_filt_o(o_filt[0]),
        .cnt_drop_runt_o(o_runt[0])
    );

    eth_llc_decode_mc #(.ACCEPT_BCAST(1'b0)) u_nobc (
        .clki(clki), .rsti(rsti), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tvalid(o_tv[1]),
        .m_axis_tlast(o_tl[1]), .m_axis_tdata(o_td[1]), .m_axis_tuser(o_tu[1]),
        .remote_mac_en_o(o_en[1]), .remote_mac_o(o_rmac[1]), .remote_ch_o(o_rch[1]),
        .cnt_clr(cnt_clr), .cnt_accept_o(o_acc[1]), .cnt_drop_filt_o(o_filt[1]),
        .cnt_drop_runt_o(o_runt[1])
    );

    eth_llc_decode_mc #(.CNT_W(4)) u_c4 (
        .clki(clki), .rsti(rsti), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tvalid(o_tv[2]),
        .m_axis_tlast(o_tl[2]), .m_axis_tdata(o_td[2]), .m_axis_tuser(o_tu[2]),
        .remote_mac_en_o(o_en[2]), .remote_mac_o(o_rmac[2]), .remote_ch_o(o_rch[2]),
        .cnt_clr(cnt_clr), .cnt_accept_o(c_acc), .cnt_drop_filt_o(c_filt),
        .cnt_drop_runt_o(c_runt)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  fr [$];
    bit          resync_m;
    bit          m_bcast [3];
    longint      m_max   [3];
    longint      m_acc   [3];
    longint      m_filt  [3];
    longint      m_runt  [3];
    logic [47:0] m_rmac  [3];
    int          m_rch   [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame outcome from the header rules: 0 runt, 1 filtered, 2 accepted, 3 discarded (resync).
    function automatic int decide(int k);
        logic [47:0] da;
        logic [15:0] lt;
        int          ch;
        if (resync_m) return 3;
        if (fr.size() <= 14) return 0;
        da = '0;
        for (int i = 0; i < 6; i++) da = (da << 8) | 48'(fr[i]);
        lt = {fr[12], fr[13]};
        ch = int'(lt % 16'd4);
        if (!(da == LOCAL || (m_bcast[k] && da == BCAST))) return 1;
        if ((lt - 16'(ch)) != 16'hFF00) return 1;
        if (ch >= 4) return 1;
        return 2;
    endfunction

    function automatic longint sat_inc(input longint v, input int k);
        return (v < m_max[k]) ? v + 1 : v;
    endfunction

    task automatic check_beat(input int k, input logic [3:0] tv, input bit last,
                              input logic [7:0] d, input bit usr, input bit en);
        chk($sformatf("tvalid[%0d]", k), 64'(o_tv[k]), 64'(tv));
        chk($sformatf("tlast[%0d]", k), 64'(o_tl[k]), 64'(last ? tv : 4'd0));
        chk($sformatf("mac_en[%0d]", k), 64'(o_en[k]), 64'(en));
        if (tv != 4'd0) begin
            chk($sformatf("tdata[%0d]", k), 64'(o_td[k]), 64'(d));
            chk($sformatf("tuser[%0d]", k), 64'(o_tu[k]), 64'(usr));
        end
    endtask

    task automatic idle_cycle();
        s_tvalid = 1'b0;
        s_tlast  = 1'($urandom);
        s_tuser  = 1'($urandom);
        s_tdata  = 8'($urandom);
        @(posedge clki); #1;
        s_tlast  = 1'b0;
        for (int k = 0; k < 3; k++) check_beat(k, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic check_state();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cnt_accept[%0d]", k), 64'(o_acc[k]), 64'(m_acc[k]));
            chk($sformatf("cnt_filt[%0d]", k), 64'(o_filt[k]), 64'(m_filt[k]));
            chk($sformatf("cnt_runt[%0d]", k), 64'(o_runt[k]), 64'(m_runt[k]));
            chk($sformatf("remote_mac[%0d]", k), 64'(o_rmac[k]), 64'(m_rmac[k]));
            chk($sformatf("remote_ch[%0d]", k), 64'(o_rch[k]), 64'(m_rch[k]));
        end
    endtask

    task automatic send_frame(input bit usr, input bit clr13, input int gap_pct);
        int          dec [3];
        int          n;
        int          ch;
        logic [47:0] sa;
        bit          pay;
        n  = fr.size();
        sa = '0;
        ch = 0;
        for (int k = 0; k < 3; k++) dec[k] = decide(k);
        if (n >= 14) begin
            for (int i = 6; i < 12; i++) sa = (sa << 8) | 48'(fr[i]);
            ch = int'({fr[12], fr[13]} % 16'd4);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0 && int'($urandom_range(99)) < gap_pct) idle_cycle();
            s_tvalid = 1'b1;
            s_tdata  = fr[i];
            s_tlast  = (i == n - 1);
            s_tuser  = (i == n - 1) ? usr : 1'($urandom);
            cnt_clr  = clr13 && (i == 13);
            @(posedge clki); #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            cnt_clr  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                pay = (dec[k] == 2) && (i >= 14);
                check_beat(k, pay ? 4'(1 << ch) : 4'd0, pay && (i == n - 1), fr[i],
                           usr && (i == n - 1), (dec[k] == 2) && (i == 13));
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (clr13) begin
                m_acc[k] = 0; m_filt[k] = 0; m_runt[k] = 0;
            end
            if (dec[k] == 0 && !clr13) m_runt[k] = sat_inc(m_runt[k], k);
            if (dec[k] == 1 && !clr13) m_filt[k] = sat_inc(m_filt[k], k);
            if (dec[k] == 2) begin
                if (!clr13) m_acc[k] = sat_inc(m_acc[k], k);
                m_rmac[k] = sa;
                m_rch[k]  = ch;
            end
        end
        resync_m = 1'b0;
        check_state();
    endtask

    task automatic build(input logic [47:0] da, input logic [47:0] sa,
                         input logic [15:0] lt, input int plen);
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(da[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(sa[i*8 +: 8]);
        fr.push_back(lt[15:8]);
        fr.push_back(lt[7:0]);
        for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
    endtask

    task automatic do_reset();
        rsti     = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clki);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_filt[k] = 0; m_runt[k] = 0; m_rmac[k] = '0; m_rch[k] = 0;
            chk($sformatf("rst_tvalid[%0d]", k), 64'(o_tv[k]), 64'd0);
            chk($sformatf("rst_tlast[%0d]", k), 64'(o_tl[k]), 64'd0);
            chk($sformatf("rst_tdata[%0d]", k), 64'(o_td[k]), 64'd0);
            chk($sformatf("rst_tuser[%0d]", k), 64'(o_tu[k]), 64'd0);
            chk($sformatf("rst_mac_en[%0d]", k), 64'(o_en[k]), 64'd0);
        end
        check_state();
        rsti     = 1'b0;
        resync_m = 1'b1;
    endtask

    initial begin
        logic [47:0] da_pick [4];
        int          n;
        m_bcast = '{1'b1, 1'b0, 1'b1};
        m_max   = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
        s_tdata = 8'd0; s_tuser = 1'b0;
        do_reset();

        // Junk frame swallowed by resync, then accepted frame to channel 2.
        fr.delete(); fr.push_back(8'hAA);
        send_frame(1'b0, 1'b0, 0);
        build(LOCAL, 48'h0A0B_0C0D_0E0F, 16'hFF02, 0);
        for (int i = 1; i <= 6; i++) fr.push_back(8'(i));
        send_frame(1'b0, 1'b0, 0);

        // Broadcast: accepted on channel 1 except where broadcast is disabled.
        build(BCAST, 48'h1122_3344_5566, 16'hFF01, 5);
        send_frame(1'b0, 1'b0, 0);

        // Wrong type, then wrong DA.
        build(LOCAL, 48'hDEAD_BEEF_0001, 16'hFE00, 4);
        send_frame(1'b0, 1'b0, 0);
        build(LOCAL ^ 48'd1, 48'hDEAD_BEEF_0002, 16'hFF02, 4);
        send_frame(1'b0, 1'b0, 0);

        // Runts: 10 bytes, then exactly 14 bytes with an otherwise valid header.
        build(LOCAL, 48'hA1A2_A3A4_A5A6, 16'hFF01, 0);
        repeat (4) void'(fr.pop_back());
        send_frame(1'b0, 1'b0, 0);
        build(LOCAL, 48'hA1A2_A3A4_A5A6, 16'hFF01, 0);
        send_frame(1'b1, 1'b0, 0);

        // Back-to-back with gaps, error flag on the second frame.
        build(LOCAL, 48'h0102_0304_0506, 16'hFF00, 9);
        send_frame(1'b0, 1'b0, 30);
        build(LOCAL, 48'h0708_090A_0B0C, 16'hFF03, 7);
        send_frame(1'b1, 1'b0, 30);

        // Clear coinciding with an accept, then saturation of the narrow counters.
        build(LOCAL, 48'h5555_6666_7777, 16'hFF01, 3);
        send_frame(1'b0, 1'b1, 0);
        repeat (17) begin
            build(LOCAL, 48'h1357_9BDF_0246, 16'hFF02, 1);
            send_frame(1'b0, 1'b0, 0);
            build(LOCAL, 48'h0, 16'h0, 0);
            repeat (12) void'(fr.pop_back());
            send_frame(1'b0, 1'b0, 0);
            build(LOCAL, 48'h2468_ACE0_1357, 16'hFF04, 1);
            send_frame(1'b0, 1'b0, 0);
        end

        // Randomized frames.
        da_pick = '{LOCAL, BCAST, LOCAL ^ 48'h0100, 48'h0};
        repeat (40) begin
            da_pick[3] = {16'($urandom), 32'($urandom)};
            build(da_pick[$urandom_range(3)], {16'($urandom), 32'($urandom)},
                  ($urandom_range(3) == 0) ? 16'($urandom) : 16'hFF00 + 16'($urandom_range(4)),
                  int'($urandom_range(12)));
            if ($urandom_range(4) == 0) begin
                n = int'($urandom_range(1, 13));
                while (fr.size() > n) void'(fr.pop_back());
            end
            send_frame(1'($urandom), (fr.size() > 14) && ($urandom_range(9) == 0), 25);
        end

        // Reset in the middle of an accepted payload, then resync and recover.
        build(LOCAL, 48'hCAFE_F00D_0001, 16'hFF03, 6);
        for (int i = 0; i < 17; i++) begin
            s_tvalid = 1'b1; s_tdata = fr[i]; s_tlast = 1'b0;
            @(posedge clki); #1;
        end
        do_reset();
        build(LOCAL, 48'hCAFE_F00D_0002, 16'hFF01, 4);
        send_frame(1'b0, 1'b0, 0);
        build(LOCAL, 48'hCAFE_F00D_0003, 16'hFF02, 4);
        send_frame(1'b1, 1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
